// File: rtl/indexador_pasos_bipolar_pkg.sv
// Shared constants, coil bundle and lookup helpers for the stepper indexer.
package indexador_pasos_bipolar_pkg;

  localparam logic [2:0] MS_FULL      = 3'b000;
  localparam logic [2:0] MS_HALF      = 3'b100;
  localparam logic [2:0] MS_QUARTER   = 3'b010;
  localparam logic [2:0] MS_EIGHTH    = 3'b110;
  localparam logic [2:0] MS_SIXTEENTH = 3'b111;

  localparam logic [5:0] INC_FULL      = 6'd16;
  localparam logic [5:0] INC_HALF      = 6'd8;
  localparam logic [5:0] INC_QUARTER   = 6'd4;
  localparam logic [5:0] INC_EIGHTH    = 6'd2;
  localparam logic [5:0] INC_SIXTEENTH = 6'd1;

  localparam logic [5:0] HOME_IDX = 6'd8;
  localparam logic [7:0] PWM_MAX  = 8'd254;

  typedef struct packed {
    logic [7:0] duty;
    logic       neg;
  } coil_t;

  function automatic logic [5:0] ms_inc(input logic [2:0] ms);
    logic [5:0] inc;
    inc = INC_FULL;
    unique case (1'b1)
      (ms == MS_HALF):      inc = INC_HALF;
      (ms == MS_QUARTER):   inc = INC_QUARTER;
      (ms == MS_EIGHTH):    inc = INC_EIGHTH;
      (ms == MS_SIXTEENTH): inc = INC_SIXTEENTH;
      default:              inc = INC_FULL;
    endcase
    return inc;
  endfunction

  // Quarter-wave table: round(255*sin(n*5.625 deg)), n = 0..16
  function automatic logic [7:0] mag(input logic [4:0] n);
    logic [7:0] m;
    m = 8'd255;
    case (n)
      5'd0:    m = 8'd0;
      5'd1:    m = 8'd25;
      5'd2:    m = 8'd50;
      5'd3:    m = 8'd74;
      5'd4:    m = 8'd98;
      5'd5:    m = 8'd120;
      5'd6:    m = 8'd142;
      5'd7:    m = 8'd162;
      5'd8:    m = 8'd180;
      5'd9:    m = 8'd197;
      5'd10:   m = 8'd212;
      5'd11:   m = 8'd225;
      5'd12:   m = 8'd236;
      5'd13:   m = 8'd244;
      5'd14:   m = 8'd250;
      5'd15:   m = 8'd254;
      default: m = 8'd255;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/indexador_pasos_bipolar_pwm_bobina.sv
// One H-bridge coil driver; registered 2-bit drive from shared PWM count.
// INDEXADOR_DECAY_RAPIDO_EN selects fast decay during the off-phase.
module pwm_bobina (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cnt,
  input  logic [7:0] duty,
  input  logic       neg,
  input  logic       en,
  output logic [1:0] drive
);

  logic [1:0] on_pol;
  logic [1:0] off_pol;

  assign on_pol = neg ? 2'b01 : 2'b10;

`ifdef INDEXADOR_DECAY_RAPIDO_EN
  assign off_pol = neg ? 2'b10 : 2'b01;
`else
  assign off_pol = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive <= 2'b00;
    end else if (!en || duty == 8'd0) begin
      drive <= 2'b00;
    end else if (cnt < duty) begin
      drive <= on_pol;
    end else begin
      drive <= off_pol;
    end
  end

endmodule

// File: rtl/indexador_pasos_bipolar.sv
// STEP/DIR/MS translator and sine-table PWM drive for a bipolar stepper.
// Option: INDEXADOR_DECAY_RAPIDO_EN (fast decay, handled in pwm_bobina).
module indexador_pasos_bipolar
  import indexador_pasos_bipolar_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PWM_PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       STEP,
  input  logic       DIR,
  input  logic [2:0] MS,
  input  logic       ENABLE_n,
  output logic [1:0] bobinaA,
  output logic [1:0] bobinaB,
  output logic [5:0] pasoIdx,
  output logic       home
);

  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PWM_PRESCALE - 1);

  logic [SYNC_STAGES-1:0]       step_sy;
  logic [SYNC_STAGES-1:0]       dir_sy;
  logic [SYNC_STAGES-1:0][2:0]  ms_sy;
  logic                         step_d;
  logic                         pulso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sy <= '0;
      dir_sy  <= '0;
      ms_sy   <= '0;
      step_d  <= 1'b0;
      pulso   <= 1'b0;
    end else begin
      step_sy <= {step_sy[SYNC_STAGES-2:0], STEP};
      dir_sy  <= {dir_sy[SYNC_STAGES-2:0], DIR};
      ms_sy   <= {ms_sy[SYNC_STAGES-2:0], MS};
      step_d  <= step_sy[SYNC_STAGES-1];
      pulso   <= step_sy[SYNC_STAGES-1] & ~step_d;
    end
  end

  logic [5:0] inc;
  logic [5:0] idx_nxt;

  assign inc = ms_inc(ms_sy[SYNC_STAGES-1]);

  always_comb begin
    idx_nxt = pasoIdx;
    if (pulso) begin
      if (dir_sy[SYNC_STAGES-1]) idx_nxt = pasoIdx + inc;
      else                       idx_nxt = pasoIdx - inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pasoIdx <= HOME_IDX;
      home    <= 1'b1;
    end else begin
      pasoIdx <= idx_nxt;
      home    <= (idx_nxt == HOME_IDX);
    end
  end

  logic [1:0] q;
  logic [4:0] kf;
  logic [4:0] kr;
  coil_t      nxt_a;
  coil_t      nxt_b;

  assign q  = pasoIdx[5:4];
  assign kf = {1'b0, pasoIdx[3:0]};
  assign kr = 5'd16 - kf;

  always_comb begin
    nxt_a = '0;
    nxt_b = '0;
    unique case (q)
      2'd0: begin
        nxt_a.duty = mag(kr);
        nxt_b.duty = mag(kf);
      end
      2'd1: begin
        nxt_a.duty = mag(kf);
        nxt_a.neg  = 1'b1;
        nxt_b.duty = mag(kr);
      end
      2'd2: begin
        nxt_a.duty = mag(kr);
        nxt_a.neg  = 1'b1;
        nxt_b.duty = mag(kf);
        nxt_b.neg  = 1'b1;
      end
      default: begin
        nxt_a.duty = mag(kf);
        nxt_b.duty = mag(kr);
        nxt_b.neg  = 1'b1;
      end
    endcase
  end

  logic [PW-1:0] pre;
  logic          tick;
  logic [7:0]    cnt;
  coil_t         lat_a;
  coil_t         lat_b;

  assign tick = (pre == PRE_LAST);

  // Duty and sign only change at the wrap so every period is whole
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      cnt   <= '0;
      lat_a <= '0;
      lat_b <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        if (cnt == PWM_MAX) begin
          cnt   <= '0;
          lat_a <= nxt_a;
          lat_b <= nxt_b;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  pwm_bobina u_bob_a (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .duty  (lat_a.duty),
    .neg   (lat_a.neg),
    .en    (~ENABLE_n),
    .drive (bobinaA)
  );

  pwm_bobina u_bob_b (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .duty  (lat_b.duty),
    .neg   (lat_b.neg),
    .en    (~ENABLE_n),
    .drive (bobinaB)
  );

endmodule

// File: tb/tb_indexador_pasos_bipolar.sv
// Bench for indexador_pasos_bipolar: vector table, hand corners, random steps.
// Coil expectations come from a cos/sin phasor model of the electrical angle.
module tb_indexador_pasos_bipolar;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       STEP = 1'b0;
  logic       DIR = 1'b0;
  logic [2:0] MS = 3'b000;
  logic       ENABLE_n = 1'b0;
  logic [1:0] bobinaA;
  logic [1:0] bobinaB;
  logic [5:0] pasoIdx;
  logic       home;

  indexador_pasos_bipolar #(.SYNC_STAGES(SS), .PWM_PRESCALE(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .STEP     (STEP),
    .DIR      (DIR),
    .MS       (MS),
    .ENABLE_n (ENABLE_n),
    .bobinaA  (bobinaA),
    .bobinaB  (bobinaB),
    .pasoIdx  (pasoIdx),
    .home     (home)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;
  int model_idx = 8;
  bit model_en = 1'b1;

  typedef struct {
    bit       dir;
    bit [2:0] ms;
    int       n;
    int       exp_idx;
    bit       exp_home;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int model_inc(input bit [2:0] ms);
    int lvl;
    case (ms)
      3'b100:  lvl = 1;
      3'b010:  lvl = 2;
      3'b110:  lvl = 3;
      3'b111:  lvl = 4;
      default: lvl = 0;
    endcase
    return 16 >> lvl;
  endfunction

  task automatic step_pulse(input bit dir, input bit [2:0] ms);
    DIR = dir;
    MS = ms;
    STEP = 1'b1;
    cyc(4);
    STEP = 1'b0;
    cyc(6);
    model_idx = (model_idx + (dir ? model_inc(ms) : -model_inc(ms)) + 64) % 64;
  endtask

  // Expected cycles per 255-cycle window spent at 10 and at 01
  task automatic coil_exp(input bit is_b, output int pos, output int neg);
    real th, v, av;
    int m;
    bit decay;
`ifdef INDEXADOR_DECAY_RAPIDO_EN
    decay = 1'b1;
`else
    decay = 1'b0;
`endif
    th = model_idx * 5.625 * 3.14159265358979 / 180.0;
    v = is_b ? 255.0 * $sin(th) : 255.0 * $cos(th);
    av = (v < 0.0) ? -v : v;
    m = $rtoi(av + 0.5);
    pos = 0;
    neg = 0;
    if (model_en && m != 0) begin
      if (v > 0.0) begin
        pos = m;
        if (decay) neg = 255 - m;
      end else begin
        neg = m;
        if (decay) pos = 255 - m;
      end
    end
  endtask

  task automatic check_coils(input string tag);
    int ap, an, bp, bn, eap, ean, ebp, ebn;
    ap = 0; an = 0; bp = 0; bn = 0;
    cyc(300);
    repeat (255) begin
      @(posedge clk);
      #1;
      if (bobinaA == 2'b10) ap++;
      if (bobinaA == 2'b01) an++;
      if (bobinaB == 2'b10) bp++;
      if (bobinaB == 2'b01) bn++;
    end
    coil_exp(1'b0, eap, ean);
    coil_exp(1'b1, ebp, ebn);
    chk({tag, "_A10"}, ap, eap);
    chk({tag, "_A01"}, an, ean);
    chk({tag, "_B10"}, bp, ebp);
    chk({tag, "_B01"}, bn, ebn);
  endtask

  initial begin
    int n;
    bit seen;
    int old;
    bit d;
    bit [2:0] m;

    tbl[0]  = '{1'b1, 3'b000, 1, 24, 1'b0};
    tbl[1]  = '{1'b1, 3'b000, 1, 40, 1'b0};
    tbl[2]  = '{1'b1, 3'b000, 1, 56, 1'b0};
    tbl[3]  = '{1'b1, 3'b000, 1, 8,  1'b1};
    tbl[4]  = '{1'b0, 3'b111, 9, 63, 1'b0};
    tbl[5]  = '{1'b1, 3'b111, 9, 8,  1'b1};
    tbl[6]  = '{1'b1, 3'b100, 1, 16, 1'b0};
    tbl[7]  = '{1'b0, 3'b110, 4, 8,  1'b1};
    tbl[8]  = '{1'b1, 3'b011, 1, 24, 1'b0};
    tbl[9]  = '{1'b0, 3'b010, 4, 8,  1'b1};
    tbl[10] = '{1'b0, 3'b101, 1, 56, 1'b0};
    tbl[11] = '{1'b1, 3'b000, 1, 8,  1'b1};

    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_idx", pasoIdx, 8);
    chk("rst_home", home, 1);
    chk("rst_A", bobinaA, 0);
    chk("rst_B", bobinaB, 0);
    cyc(100);
    chk("prewrap_A", bobinaA, 0);
    chk("prewrap_B", bobinaB, 0);
    check_coils("home");

    // STEP latency: count edges after the one that first samples STEP
    old = pasoIdx;
    DIR = 1'b1;
    MS = 3'b000;
    STEP = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (pasoIdx != old) begin
        n = i;
        seen = 1'b1;
      end
    end
    chk("step_latency", n, SS + 1);
    STEP = 1'b0;
    cyc(6);
    model_idx = 24;
    chk("lat_idx", pasoIdx, 24);
    step_pulse(1'b1, 3'b000);
    step_pulse(1'b1, 3'b000);
    step_pulse(1'b1, 3'b000);
    chk("lat_back_idx", pasoIdx, 8);

    for (int v = 0; v < 12; v++) begin
      for (int s = 0; s < tbl[v].n; s++) step_pulse(tbl[v].dir, tbl[v].ms);
      chk($sformatf("tbl%0d_idx", v), pasoIdx, tbl[v].exp_idx);
      chk($sformatf("tbl%0d_home", v), home, tbl[v].exp_home);
      check_coils($sformatf("tbl%0d", v));
    end

    // Disabled drive still steps
    ENABLE_n = 1'b1;
    model_en = 1'b0;
    cyc(1);
    chk("dis_A", bobinaA, 0);
    chk("dis_B", bobinaB, 0);
    old = model_idx;
    for (int s = 0; s < 3; s++) step_pulse(1'b1, 3'b010);
    chk("dis_idx", pasoIdx, (old + 12) % 64);
    check_coils("dis");
    ENABLE_n = 1'b0;
    model_en = 1'b1;
    check_coils("reen");

    for (int r = 0; r < 40; r++) begin
      d = 1'($urandom_range(0, 1));
      m = 3'($urandom_range(0, 7));
      step_pulse(d, m);
      chk($sformatf("rnd%0d_idx", r), pasoIdx, model_idx);
      chk($sformatf("rnd%0d_home", r), home, (model_idx == 8) ? 1 : 0);
      if (r % 10 == 9) check_coils($sformatf("rnd%0d", r));
    end

    // Async reset mid on-phase at index 40
    for (int s = 0; s < 64 && model_idx != 40; s++) step_pulse(1'b1, 3'b111);
    chk("pre_rst_idx", pasoIdx, 40);
    cyc(300);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (bobinaA != 2'b00) seen = 1'b1;
    end
    chk("rst_wait_on", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_idx", pasoIdx, 8);
    chk("arst_home", home, 1);
    chk("arst_A", bobinaA, 0);
    chk("arst_B", bobinaB, 0);
    cyc(2);
    rst_n = 1'b1;
    model_idx = 8;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
